timer_mmss_down_counter: RTL and testbench

// - MM:SS countdown timer stage; consumes D[3:0], loadn and pgt_1Hz from encoder_timer_input_control.
// - While idle, keypad digits shift in from the right (calculator style); while enabled, counts down once per pgt_1Hz rising edge.
// - Drives four BCD digits to the display decoders, plus zero/done flags to the magnetron/control logic.

---
 rtl/timer_mmss_down_counter.sv | 128 ++++++++++++
 tb/tb_timer_mmss_down_counter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_mmss_down_counter.sv
// MM:SS countdown timer: calculator-style BCD digit entry while idle, 1 Hz countdown while running.
// Optional build macro TIMER_SEC_CLAMP_EN clamps a shifted-in seconds-tens digit to SEC_TENS_MAX.
//
// state | meaning
// IDLE  | all digits zero, not counting
// SET   | digits nonzero, entry allowed (enablen=1 or paused)
// RUN   | counting down on each 1 Hz tick
// DONE  | countdown just reached 0000; done pulses here for one cycle
module timer_mmss_down_counter #(
  parameter logic [3:0] SEC_TENS_MAX = 4'd5,
  parameter logic [3:0] SEC_ONES_MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       enablen,
  input  logic       clearn,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SET, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic       loadn_q, tick_q;
  logic       loadn_fall, tick_rise, load_ok;
  logic [3:0] mt_nxt, mo_nxt, st_nxt, so_nxt;
  logic [3:0] mt_dec, mo_dec, st_dec, so_dec;
  logic [3:0] ld_sec_tens;
  logic       b_so, b_st, b_mo;

  assign loadn_fall = loadn_q & ~loadn;
  assign tick_rise  = pgt_1Hz & ~tick_q;
  assign load_ok    = loadn_fall && (D <= 4'd9);
  assign zero       = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                      (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign done       = (state == DONE);

`ifdef TIMER_SEC_CLAMP_EN
  assign ld_sec_tens = (sec_ones > SEC_TENS_MAX) ? SEC_TENS_MAX : sec_ones;
`else
  assign ld_sec_tens = sec_ones;
`endif

  // Borrow chain; out-of-range seconds tens simply counts down toward the reload value.
  always_comb begin
    b_so   = (sec_ones == 4'd0);
    so_dec = b_so ? SEC_ONES_MAX : sec_ones - 4'd1;
    b_st   = b_so && (sec_tens == 4'd0);
    st_dec = b_so ? ((sec_tens == 4'd0) ? SEC_TENS_MAX : sec_tens - 4'd1) : sec_tens;
    b_mo   = b_st && (min_ones == 4'd0);
    mo_dec = b_st ? ((min_ones == 4'd0) ? 4'd9 : min_ones - 4'd1) : min_ones;
    mt_dec = b_mo ? min_tens - 4'd1 : min_tens;
  end

  always_comb begin
    state_nxt = state;
    mt_nxt    = min_tens;
    mo_nxt    = min_ones;
    st_nxt    = sec_tens;
    so_nxt    = sec_ones;
    if (!clearn) begin
      state_nxt = IDLE;
      mt_nxt    = 4'd0;
      mo_nxt    = 4'd0;
      st_nxt    = 4'd0;
      so_nxt    = 4'd0;
    end else begin
      case (state)
        IDLE, SET: begin
          if (load_ok) begin
            mt_nxt = min_ones;
            mo_nxt = sec_tens;
            st_nxt = ld_sec_tens;
            so_nxt = D;
          end
          if (!enablen && !zero)
            state_nxt = RUN;
          else if ({mt_nxt, mo_nxt, st_nxt, so_nxt} != 16'h0000)
            state_nxt = SET;
          else
            state_nxt = IDLE;
        end
        RUN: begin
          if (enablen) begin
            state_nxt = SET;
          end else if (tick_rise && !zero) begin
            mt_nxt = mt_dec;
            mo_nxt = mo_dec;
            st_nxt = st_dec;
            so_nxt = so_dec;
            if ({mt_dec, mo_dec, st_dec, so_dec} == 16'h0000)
              state_nxt = DONE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      loadn_q  <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      min_tens <= mt_nxt;
      min_ones <= mo_nxt;
      sec_tens <= st_nxt;
      sec_ones <= so_nxt;
      loadn_q  <= loadn;
      tick_q   <= pgt_1Hz;
    end
  end

endmodule

// File: tb/tb_timer_mmss_down_counter.sv
// Bench for timer_mmss_down_counter: directed scenarios plus random stimulus against a
// minutes/seconds number model.
module tb_timer_mmss_down_counter;

  logic       clk = 1'b0;
  logic       rst, loadn, pgt_1Hz, enablen, clearn;
  logic [3:0] D;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       zero, done;
  logic [17:0] obs;

  int checks = 0;
  int failures = 0;

  // Model: displayed value as a 4-digit decimal number MMSS (seconds part may exceed 59).
  int   m_n;
  bit   m_run, m_done, m_loadn_q, m_tick_q;

  always #5 clk = ~clk;

  timer_mmss_down_counter dut (
    .clk(clk), .rst(rst), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
    .enablen(enablen), .clearn(clearn),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .zero(zero), .done(done)
  );

  assign obs = {min_tens, min_ones, sec_tens, sec_ones, zero, done};

  function automatic logic [17:0] exp_vec();
    return {4'(m_n / 1000), 4'((m_n / 100) % 10), 4'((m_n / 10) % 10), 4'(m_n % 10),
            m_n == 0, m_done};
  endfunction

  function automatic logic [17:0] vec(input logic [15:0] digits, input logic z, input logic dn);
    return {digits, z, dn};
  endfunction

  // Drive one cycle of inputs, clock it, advance the model, settle.
  task automatic cyc(input bit r, input bit cl, input bit en, input bit ld,
                     input logic [3:0] d, input bit tk);
    bit lf, tr;
    int old, m, s;
    rst = r; clearn = cl; enablen = en; loadn = ld; D = d; pgt_1Hz = tk;
    @(posedge clk);
    lf = m_loadn_q && !ld;
    tr = tk && !m_tick_q;
    m_loadn_q = ld;
    m_tick_q  = tk;
    if (r) begin
      m_n = 0; m_run = 0; m_done = 0; m_loadn_q = 1; m_tick_q = 0;
    end else if (!cl) begin
      m_n = 0; m_run = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_run) begin
      if (en) m_run = 0;
      else if (tr && m_n != 0) begin
        m = m_n / 100; s = m_n % 100;
        if (s > 0) s = s - 1;
        else begin m = m - 1; s = 59; end
        m_n = m * 100 + s;
        if (m_n == 0) begin m_run = 0; m_done = 1; end
      end
    end else begin
      old = m_n;
      if (lf && d <= 9) begin
        m_n = (m_n % 1000) * 10 + int'(d);
`ifdef TIMER_SEC_CLAMP_EN
        if ((m_n / 10) % 10 > 5) m_n = m_n - (((m_n / 10) % 10) - 5) * 10;
`endif
      end
      if (!en && old != 0) m_run = 1;
    end
    #1;
  endtask

  task automatic key(input logic [3:0] d, input bit en);
    cyc(0, 1, en, 0, d, 0);
    cyc(0, 1, en, 1, d, 0);
  endtask

  task automatic tick(input bit en);
    cyc(0, 1, en, 1, 4'd0, 1);
    cyc(0, 1, en, 1, 4'd0, 0);
  endtask

  task automatic test_reset();
    cyc(1, 1, 1, 1, 4'd0, 0);
    cyc(1, 1, 1, 1, 4'd0, 0);
    checks++;
    if (obs !== vec(16'h0000, 1, 0)) begin
      failures++; $display("FAIL reset got=%h exp=%h", obs, vec(16'h0000, 1, 0));
    end
    cyc(0, 1, 0, 1, 4'd0, 1);
    cyc(0, 1, 0, 1, 4'd0, 0);
    checks++;
    if (obs !== vec(16'h0000, 1, 0)) begin
      failures++; $display("FAIL idle_tick got=%h exp=%h", obs, vec(16'h0000, 1, 0));
    end
  endtask

  task automatic test_load();
    key(4'd1, 1); key(4'd3, 1); key(4'd0, 1);
    checks++;
    if (obs !== vec(16'h0130, 0, 0)) begin
      failures++; $display("FAIL load_130 got=%h exp=%h", obs, vec(16'h0130, 0, 0));
    end
    key(4'hC, 1);
    checks++;
    if (obs !== vec(16'h0130, 0, 0)) begin
      failures++; $display("FAIL load_bad_digit got=%h exp=%h", obs, vec(16'h0130, 0, 0));
    end
  endtask

  task automatic test_done();
    cyc(0, 0, 1, 1, 4'd0, 0);
    key(4'd2, 1);
    cyc(0, 1, 0, 1, 4'd0, 0);
    tick(0);
    checks++;
    if (obs !== vec(16'h0001, 0, 0)) begin
      failures++; $display("FAIL count_0001 got=%h exp=%h", obs, vec(16'h0001, 0, 0));
    end
    cyc(0, 1, 0, 1, 4'd0, 1);
    checks++;
    if (obs !== vec(16'h0000, 1, 1)) begin
      failures++; $display("FAIL done_pulse got=%h exp=%h", obs, vec(16'h0000, 1, 1));
    end
    cyc(0, 1, 0, 1, 4'd0, 0);
    checks++;
    if (obs !== vec(16'h0000, 1, 0)) begin
      failures++; $display("FAIL done_width got=%h exp=%h", obs, vec(16'h0000, 1, 0));
    end
    tick(0);
    checks++;
    if (obs !== vec(16'h0000, 1, 0)) begin
      failures++; $display("FAIL no_underflow got=%h exp=%h", obs, vec(16'h0000, 1, 0));
    end
  endtask

  task automatic test_borrow();
    cyc(0, 0, 1, 1, 4'd0, 0);
    key(4'd1, 1); key(4'd0, 1); key(4'd0, 1); key(4'd0, 1);
    cyc(0, 1, 0, 1, 4'd0, 0);
    tick(0);
    checks++;
    if (obs !== vec(16'h0959, 0, 0)) begin
      failures++; $display("FAIL borrow_1000 got=%h exp=%h", obs, vec(16'h0959, 0, 0));
    end
    cyc(0, 0, 1, 1, 4'd0, 0);
    key(4'd1, 1); key(4'd0, 1); key(4'd0, 1);
    cyc(0, 1, 0, 1, 4'd0, 0);
    tick(0);
    checks++;
    if (obs !== vec(16'h0059, 0, 0)) begin
      failures++; $display("FAIL borrow_0100 got=%h exp=%h", obs, vec(16'h0059, 0, 0));
    end
  endtask

  task automatic test_pause();
    cyc(0, 0, 1, 1, 4'd0, 0);
    key(4'd4, 1); key(4'd5, 1);
    cyc(0, 1, 0, 1, 4'd0, 0);
    key(4'd7, 0);
    checks++;
    if (obs !== vec(16'h0045, 0, 0)) begin
      failures++; $display("FAIL run_load_ignored got=%h exp=%h", obs, vec(16'h0045, 0, 0));
    end
    cyc(0, 1, 1, 1, 4'd0, 0);
    tick(1); tick(1);
    checks++;
    if (obs !== vec(16'h0045, 0, 0)) begin
      failures++; $display("FAIL pause_hold got=%h exp=%h", obs, vec(16'h0045, 0, 0));
    end
    cyc(0, 1, 0, 1, 4'd0, 1);
    cyc(0, 1, 0, 1, 4'd0, 0);
    tick(0);
    checks++;
    if (obs !== vec(16'h0044, 0, 0)) begin
      failures++; $display("FAIL resume got=%h exp=%h", obs, vec(16'h0044, 0, 0));
    end
  endtask

  task automatic test_clear();
    cyc(0, 0, 0, 1, 4'd0, 0);
    checks++;
    if (obs !== vec(16'h0000, 1, 0)) begin
      failures++; $display("FAIL clear_run got=%h exp=%h", obs, vec(16'h0000, 1, 0));
    end
    tick(0);
    checks++;
    if (obs !== vec(16'h0000, 1, 0)) begin
      failures++; $display("FAIL clear_idle got=%h exp=%h", obs, vec(16'h0000, 1, 0));
    end
  endtask

  task automatic test_sec_range();
    logic [15:0] e79, e59;
`ifdef TIMER_SEC_CLAMP_EN
    e79 = 16'h0059; e59 = 16'h0039;
`else
    e79 = 16'h0079; e59 = 16'h0059;
`endif
    cyc(0, 0, 1, 1, 4'd0, 0);
    key(4'd7, 1); key(4'd9, 1);
    checks++;
    if (obs !== vec(e79, 0, 0)) begin
      failures++; $display("FAIL entry_79 got=%h exp=%h", obs, vec(e79, 0, 0));
    end
    cyc(0, 1, 0, 1, 4'd0, 0);
    for (int i = 0; i < 20; i++) tick(0);
    checks++;
    if (obs !== vec(e59, 0, 0)) begin
      failures++; $display("FAIL range_count got=%h exp=%h", obs, vec(e59, 0, 0));
    end
  endtask

  task automatic test_random();
    bit r, cl, en, ld, tk;
    logic [3:0] d;
    en = 1; ld = 1; tk = 0;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 499) == 0);
      cl = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 3) == 0) ld = ~ld;
      tk = ($urandom_range(0, 2) == 0) ? ~tk : tk;
      d  = 4'($urandom_range(0, 15));
      cyc(r, cl, en, ld, d, tk);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL random_%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1; clearn = 1; enablen = 1; loadn = 1; pgt_1Hz = 0; D = 4'd0;
    m_n = 0; m_run = 0; m_done = 0; m_loadn_q = 1; m_tick_q = 0;
    test_reset();
    test_load();
    test_done();
    test_borrow();
    test_pause();
    test_clear();
    test_sec_range();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
